// File: rtl/updown_counter_param_if.sv
// Control/status bundle for updown_counter_param.
// The master drives the controls and the slave (the counter) returns its status.
interface updown_counter_param_if #(
  parameter int WIDTH = 5
);
  logic             en;
  logic             up_dn;
  logic             sat_mode;
  logic [WIDTH-1:0] limit;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic             at_min;
  logic             at_max;

  modport master (
    output en, up_dn, sat_mode, limit, load, load_val,
    input  count, wrap, at_min, at_max
  );

  modport slave (
    input  en, up_dn, sat_mode, limit, load, load_val,
    output count, wrap, at_min, at_max
  );
endinterface

// File: rtl/updown_counter_param.sv
// Programmable up/down counter over the range [0..limit].
// Supports wrap or saturate at the boundaries, parallel load, and status flags.
module updown_counter_param #(
  parameter int               WIDTH     = 5,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic                         clk,
  input  logic                         reset,
  updown_counter_param_if.slave        bus
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             hit_top, hit_bot;

  // A count above limit counts as "at the top", so an up step from there is a boundary event.
  assign hit_top = (cnt_q >= bus.limit);
  assign hit_bot = (cnt_q == '0);

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      cnt_d = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (!hit_top)           cnt_d = cnt_q + 1'b1;
        else begin
          wrap_d = 1'b1;
          if (!bus.sat_mode)    cnt_d = '0;
        end
      end else begin
        // An out-of-range value decays by one per step until it re-enters the range.
        if (!hit_bot)           cnt_d = cnt_q - 1'b1;
        else begin
          wrap_d = 1'b1;
          if (!bus.sat_mode)    cnt_d = bus.limit;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= RESET_VAL;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.count  = cnt_q;
  assign bus.wrap   = wrap_q;
  assign bus.at_min = hit_bot;
  assign bus.at_max = hit_top;

endmodule
